serial_digit_adder: RTL

- Parametrised sequential successor to the fixed 4-bit ripple-carry adder slices in the partition set.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB digit first, through one shared DIGIT-bit ripple slice.
- Uses a valid/ready handshake on input and output.
- Gives area/latency trade-off points for approximate-synthesis experiments. Adds carry-in, subtract mode, carry-out and signed overflow.

---
 rtl/serial_adder_pkg.sv | 32 +++
 rtl/serial_digit_adder_if.sv | 29 ++
 rtl/adder_slice.sv | 30 +++
 rtl/serial_digit_adder.sv | 133 +++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants and elaboration helpers for the digit-serial adder.
// Exports: state encodings, digit-count / counter-width functions,
// parameter legality check.
package serial_adder_pkg;

    typedef logic [1:0] state_t;

    // State encodings of the serial adder FSM.
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Number of digits in one operand; zero for an illegal DIGIT.
    function automatic int unsigned calc_ndig(input int unsigned width, input int unsigned digit);
        if (digit == 0) return 0;
        return width / digit;
    endfunction

    // Digit counter width, never below one bit.
    function automatic int unsigned calc_cnt_width(input int unsigned ndig);
        if (ndig <= 1) return 1;
        return $clog2(ndig);
    endfunction

    // WIDTH must be a positive multiple of a positive DIGIT.
    function automatic bit params_legal(input int unsigned width, input int unsigned digit);
        if (digit == 0) return 1'b0;
        if (width < digit) return 1'b0;
        return (width % digit) == 0;
    endfunction

endpackage

// File: rtl/serial_digit_adder_if.sv
// Handshake bus of the digit-serial adder.
// Input side: in_valid/in_ready with operands a, b, cin, sub.
// Output side: out_valid/out_ready with result sum, cout, ovf.
// master = producer/consumer environment, slave = adder.
interface serial_digit_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/adder_slice.sv
// Combinational DIGIT-bit ripple-carry adder slice.
// Ports: x, y operands; ci carry in; s sum; co carry out of the top bit;
// c_msb_in carry into the top bit (for signed overflow).
module adder_slice #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [DIGIT:0] c;

    // Bitwise ripple: c[i] is the carry into bit i.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < int'(DIGIT); i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        co       = c[DIGIT];
        c_msb_in = c[DIGIT-1];
    end

endmodule

// File: rtl/serial_digit_adder.sv
// Digit-serial add/subtract unit: WIDTH-bit operands processed DIGIT bits
// per clock, least significant digit first, through one shared slice.
// Ports: clk, rst_n (synchronous, active-low), bus (slave side of the
// valid/ready operand and result handshake).
module serial_digit_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_digit_adder_if.slave  bus
);

    localparam int unsigned NDIG = calc_ndig(WIDTH, DIGIT);
    localparam int unsigned CW   = calc_cnt_width(NDIG);

    if (!params_legal(WIDTH, DIGIT)) begin : g_bad_params
        $error("serial_digit_adder: WIDTH must be a positive multiple of DIGIT");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [DIGIT-1:0] slice_s;
    logic             slice_co;
    logic             slice_c_msb;

    // Operands shift right each digit, so the slice always sees the low digit.
    adder_slice #(.DIGIT(DIGIT)) u_slice (
        .x        (DIGIT'(a_q)),
        .y        (DIGIT'(b_q)),
        .ci       (carry_q),
        .s        (slice_s),
        .co       (slice_co),
        .c_msb_in (slice_c_msb)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    // Subtraction folds into addition of ~b with inverted carry.
                    state_d = RUN;
                    a_d     = bus.a;
                    b_d     = bus.b ^ {WIDTH{bus.sub}};
                    carry_d = bus.cin ^ bus.sub;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            RUN: begin
                // New digit enters at the top; after NDIG digits it sits at bit 0.
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = slice_co;
                acc_d   = (acc_q >> DIGIT) | (WIDTH'(slice_s) << (WIDTH - DIGIT));
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NDIG - 1)) begin
                    state_d = DONE;
                    cnt_d   = cnt_q;
                    sum_d   = acc_d;
                    cout_d  = slice_co;
                    ovf_d   = slice_c_msb ^ slice_co;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            acc_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule
